// File: rtl/led_bank_arbiter.sv
// Round-robin owner of one shared LED bar, min-hold timeslice, one blank gap cycle between owners.
// Latency: grant 1 cycle after req sampled, LEDs 1 cycle behind grant; no backpressure (level req).
// Optional macro LED_ARB_LOCK_EN adds a `lock` input that holds off timeslice preemption.
module led_bank_arbiter #(
    parameter int N_REQ    = 4,
    parameter int LED_W    = 10,
    parameter int HOLD_CYC = 50_000_000,
    parameter int CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LED_W-1:0] req_leds,
`ifdef LED_ARB_LOCK_EN
    input  logic                   lock,
`endif
    output logic [N_REQ-1:0]       grant,
    output logic [LED_W-1:0]       LEDs,
    output logic [2:0]             segments,
    output logic                   busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] hold_cnt;

    logic             lock_act;
    logic             owner_req;
    logic             others_wait;
    logic [IDX_W-1:0] next_owner;
    logic [LED_W-1:0] owner_leds;

`ifdef LED_ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    // grant is the one-hot of owner while in GRANT, so it doubles as the owner mask
    assign owner_req   = |(req & grant);
    assign others_wait = |(req & ~grant);
    assign owner_leds  = req_leds[owner*LED_W +: LED_W];

    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] l);
        logic [IDX_W-1:0] idx;
        logic             found;
        int               c;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            c = (int'(l) + i) % N_REQ;
            if (!found && r[c]) begin
                idx   = IDX_W'(c);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign next_owner = rr_pick(req, last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            owner    <= '0;
            last     <= IDX_W'(N_REQ - 1);
            hold_cnt <= '0;
            grant    <= '0;
            LEDs     <= '0;
            segments <= 3'b011;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_GAP: begin
                    LEDs <= '0;
                    if (|req) begin
                        state    <= S_GRANT;
                        owner    <= next_owner;
                        grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << next_owner;
                        hold_cnt <= '0;
                        segments <= 3'b110;
                        busy     <= 1'b1;
                    end else begin
                        state    <= S_IDLE;
                        grant    <= '0;
                        segments <= 3'b011;
                        busy     <= 1'b0;
                    end
                end
                S_GRANT: begin
                    // release and expiry both land in GAP, so a single branch covers rules 1 and 2
                    if (!owner_req || (hold_cnt == HOLD_MAX && others_wait && !lock_act)) begin
                        state    <= S_GAP;
                        last     <= owner;
                        grant    <= '0;
                        LEDs     <= '0;
                        segments <= 3'b101;
                        busy     <= 1'b0;
                    end else begin
                        LEDs <= owner_leds;
                        if (hold_cnt != HOLD_MAX)
                            hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    grant    <= '0;
                    LEDs     <= '0;
                    segments <= 3'b011;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with N_REQ=4, LED_W=10, HOLD_CYC=8.
module tb_led_bank_arbiter;

    localparam int N_REQ = 4;
    localparam int LED_W = 10;
    localparam int HOLD  = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LED_W-1:0] req_leds;
    logic [N_REQ-1:0]       grant;
    logic [LED_W-1:0]       LEDs;
    logic [2:0]             segments;
    logic                   busy;
`ifdef LED_ARB_LOCK_EN
    logic                   lock;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [LED_W-1:0] led_word [N_REQ];

    led_bank_arbiter #(
        .N_REQ(N_REQ), .LED_W(LED_W), .HOLD_CYC(HOLD), .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_leds(req_leds),
`ifdef LED_ARB_LOCK_EN
        .lock(lock),
`endif
        .grant(grant),
        .LEDs(LEDs),
        .segments(segments),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_leds"},  32'(LEDs), 32'h0);
        chk({tag, "_seg"},   32'(segments), 32'b011);
        chk({tag, "_busy"},  32'(busy), 32'h0);
    endtask

    task automatic chk_gap(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_leds"},  32'(LEDs), 32'h0);
        chk({tag, "_seg"},   32'(segments), 32'b101);
        chk({tag, "_busy"},  32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog run did not finish");
        $fatal(1);
    end

    initial begin
        int rr_seq [4];
        rr_seq = '{0, 1, 3, 0};
        led_word[0] = 10'h101;
        led_word[1] = 10'h152;
        led_word[2] = 10'h2A5;
        led_word[3] = 10'h3C3;
        req_leds = {led_word[3], led_word[2], led_word[1], led_word[0]};
`ifdef LED_ARB_LOCK_EN
        lock = 1'b0;
`endif

        // Reset with all requests high
        rst_n = 1'b0;
        req   = 4'hF;
        tick();
        tick();
        chk_idle("reset");

        // Single requester: never preempted, no gap
        rst_n = 1'b1;
        req   = 4'b0100;
        tick();
        chk("single_grant0", 32'(grant), 32'b0100);
        chk("single_leds0",  32'(LEDs), 32'h0);
        chk("single_seg0",   32'(segments), 32'b110);
        chk("single_busy0",  32'(busy), 32'h1);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("single_grant", 32'(grant), 32'b0100);
            chk("single_leds",  32'(LEDs), 32'h2A5);
            chk("single_seg",   32'(segments), 32'b110);
        end
        req = 4'b0000;
        tick();
        chk_gap("single_rel");
        tick();
        chk_idle("single_idle");

        // Round robin from a fresh reset: 0,1,3,0 with 8-cycle slices and one gap
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b1011;
        tick();
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < HOLD; c++) begin
                chk("rr_grant", 32'(grant), 32'(4'b0001 << rr_seq[o]));
                chk("rr_seg",   32'(segments), 32'b110);
                chk("rr_leds",  32'(LEDs), (c == 0) ? 32'h0 : 32'(led_word[rr_seq[o]]));
                chk("rr_onehot", 32'($countones(grant)), 32'h1);
                tick();
            end
            chk_gap("rr_gap");
            if (o < 3) tick();
        end

        // Early release: owner 1 drops at hold_cnt=3
        tick();
        chk("er_grant1", 32'(grant), 32'b0010);
        tick();
        tick();
        tick();
        chk("er_hold3", 32'(grant), 32'b0010);
        req = 4'b1001;
        tick();
        chk_gap("er_gap");
        tick();
        chk("er_next3", 32'(grant), 32'b1000);
        chk("er_seg",   32'(segments), 32'b110);

        // Owner 3 releases, owner 2 takes over; reset at hold_cnt=5
        req = 4'b0100;
        tick();
        chk_gap("mr_gap");
        tick();
        chk("mr_grant2", 32'(grant), 32'b0100);
        for (int i = 0; i < 5; i++) tick();
        chk("mr_leds", 32'(LEDs), 32'h2A5);
        rst_n = 1'b0;
        tick();
        chk_idle("mr_reset");
        rst_n = 1'b1;
        req   = 4'b0101;
        tick();
        chk("mr_after0", 32'(grant), 32'b0001);

        // Simultaneous release and expiry still goes to GAP, then round robin continues
        for (int i = 0; i < HOLD - 1; i++) tick();
        chk("sim_hold7", 32'(grant), 32'b0001);
        req = 4'b0100;
        tick();
        chk_gap("sim_gap");
        tick();
        chk("sim_next2", 32'(grant), 32'b0100);

`ifdef LED_ARB_LOCK_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b0011;
        lock  = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("lock_hold", 32'(grant), 32'b0001);
            tick();
        end
        lock = 1'b0;
        tick();
        chk_gap("lock_gap");
        tick();
        chk("lock_next1", 32'(grant), 32'b0010);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
